// File: rtl/mult_sequencer.sv
// Control FSM for the shift-add signed multiplier: turns run/clear-load button
// levels into datapath strobes. Optional macro MULT_SEQ_SKIP_EN folds the shift into EVAL when b0=0.
module mult_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          clra_ldb,
  input  logic          b0,
  output logic          cleara,
  output logic          loadb,
  output logic          add,
  output logic          sub,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_EVAL,
    S_SHIFT,
    S_HOLD
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_run_q;
  logic          r_clq_q;
  logic          w_run_ev;
  logic          w_load_ev;
  logic          w_last;

  // A held button level produces a single event on its rising edge.
  assign w_run_ev  = run & ~r_run_q;
  assign w_load_ev = clra_ldb & ~r_clq_q;
  assign w_last    = (r_count == LAST);
  assign count     = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_run_q <= 1'b0;
      r_clq_q <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_run_q <= run;
      r_clq_q <= clra_ldb;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    cleara       = 1'b0;
    loadb        = 1'b0;
    add          = 1'b0;
    sub          = 1'b0;
    shift        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Load wins a tie; the coincident run edge is consumed and lost.
        if (w_load_ev) begin
          cleara = 1'b1;
          loadb  = 1'b1;
        end else if (w_run_ev) begin
          w_state_next = S_CLR;
        end
      end
      S_CLR: begin
        busy         = 1'b1;
        cleara       = 1'b1;
        w_count_next = '0;
        w_state_next = S_EVAL;
      end
      S_EVAL: begin
        busy = 1'b1;
        if (b0) begin
          // The MSB of a two's-complement multiplier carries negative weight.
          add          = ~w_last;
          sub          = w_last;
          w_state_next = S_SHIFT;
        end else begin
`ifdef MULT_SEQ_SKIP_EN
          shift = 1'b1;
          if (w_last) begin
            w_state_next = S_HOLD;
          end else begin
            w_count_next = r_count + CW'(1);
            w_state_next = S_EVAL;
          end
`else
          w_state_next = S_SHIFT;
`endif
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (w_last) begin
          w_state_next = S_HOLD;
        end else begin
          w_count_next = r_count + CW'(1);
          w_state_next = S_EVAL;
        end
      end
      S_HOLD: begin
        done = 1'b1;
        if (!run) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: per-cycle expected strobe vectors are
// queued when a run is launched and popped/compared each cycle.
module tb_mult_sequencer;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          clra_ldb;
  logic          b0;
  logic          cleara, loadb, add, sub, shift, busy, done;
  logic [CW-1:0] count;

  logic [W-1:0]  sw;
  logic [W-1:0]  b_shadow;
  logic [15:0]   exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cur_count = 0;

  mult_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .clra_ldb (clra_ldb),
    .b0       (b0),
    .cleara   (cleara),
    .loadb    (loadb),
    .add      (add),
    .sub      (sub),
    .shift    (shift),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  // Minimal model of the B register as seen through its LSB.
  always @(posedge clk) begin
    if (loadb)      b_shadow <= sw;
    else if (shift) b_shadow <= {1'b0, b_shadow[W-1:1]};
  end
  assign b0 = b_shadow[0];

  function automatic logic [15:0] mk(input bit cl, input bit lb, input bit ad,
                                     input bit sb, input bit sh, input bit bz,
                                     input bit dn, input int cnt);
    logic [CW-1:0] c;
    c = CW'(cnt);
    return {5'b0, cl, lb, ad, sb, sh, bz, dn, c};
  endfunction

  function automatic logic [15:0] got_vec();
    return {5'b0, cleara, loadb, add, sub, shift, busy, done, count};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cl lb ad sb sh bz dn cnt)", tag, got, exp);
    end
  endtask

  // Expected cycle-by-cycle trace from the cycle after the run edge.
  task automatic push_trace(input logic [W-1:0] b, input int rel_c, input int prev_cnt);
    bit skip;
    int hold_start, nh;
`ifdef MULT_SEQ_SKIP_EN
    skip = 1'b1;
`else
    skip = 1'b0;
`endif
    exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0, prev_cnt));
    for (int k = 0; k < W; k++) begin
      bit bit_k, last;
      bit_k = b[k];
      last  = (k == W - 1);
      exp_q.push_back(mk(0, 0, bit_k & ~last, bit_k & last, skip & ~bit_k, 1, 0, k));
      if (bit_k || !skip) exp_q.push_back(mk(0, 0, 0, 0, 1, 1, 0, k));
    end
    hold_start = exp_q.size() + 1;
    nh = (rel_c >= hold_start) ? rel_c - hold_start + 1 : 1;
    for (int h = 0; h < nh; h++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, W - 1));
    for (int h = 0; h < 3; h++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, W - 1));
  endtask

  task automatic load_b(input logic [W-1:0] b);
    @(negedge clk);
    sw = b;
    clra_ldb = 1'b1;
    #1 check("load_pulse", got_vec(), mk(1, 1, 0, 0, 0, 0, 0, cur_count));
    @(negedge clk);
    #1 check("load_once", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, cur_count));
    clra_ldb = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] b, input int rel_c, input int inj, input int rst_c);
    int  c;
    bit  stop;
    logic [15:0] e;
    load_b(b);
    push_trace(b, rel_c, cur_count);
    @(negedge clk);
    run = 1'b1;
    c = 0;
    stop = 1'b0;
    while (exp_q.size() > 0 && !stop) begin
      @(negedge clk);
      c++;
      e = exp_q.pop_front();
      check($sformatf("B%02h_cyc%0d", b, c), got_vec(), e);
      if (c == rel_c) run = 1'b0;
      if (c == inj) clra_ldb = 1'b1;
      if (c == inj + 1) clra_ldb = 1'b0;
      if (c == rst_c) begin
        reset = 1'b1;
        #1 check("rst_async", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_idle", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.delete();
        stop = 1'b1;
      end
    end
    cur_count = (rst_c > 0) ? 0 : W - 1;
  endtask

  initial begin
    reset    = 1'b1;
    run      = 1'b0;
    clra_ldb = 1'b0;
    sw       = '0;
    b_shadow = '0;
    @(negedge clk);
    #1 check("reset_state", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
    #1 check("post_reset", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, 0));

    run_op(8'h03, 1, 0, 0);
    run_op(8'h80, 1, 6, 0);
    run_op(8'h5A, 100, 0, 0);
    run_op(8'h00, 1, 0, 0);
    run_op(8'hFF, 1, 0, 0);
    run_op(8'hFF, 1, 0, 9);
    run_op(8'h03, 1, 0, 0);

    // Coincident load and run edges in IDLE: load only, run dropped.
    @(negedge clk);
    sw = 8'h11;
    clra_ldb = 1'b1;
    run = 1'b1;
    #1 check("tie_load", got_vec(), mk(1, 1, 0, 0, 0, 0, 0, cur_count));
    @(negedge clk);
    #1 check("tie_no_run", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, cur_count));
    @(negedge clk);
    #1 check("tie_still_idle", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, cur_count));
    clra_ldb = 1'b0;
    run = 1'b0;
    @(negedge clk);
    #1 check("tie_idle_after", got_vec(), mk(0, 0, 0, 0, 0, 0, 0, cur_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
